// File: rtl/elevator_req_queue_pkg.sv
// Shared sizing defaults for the elevator request queue and its index-width helper.
package elevator_req_queue_pkg;

    localparam int FLOOR_W   = 4;
    localparam int DEPTH_DEF = 16;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/elevator_req_queue.sv
// Floor-request FIFO: flat shift-on-pop register bank with explicit count,
// duplicate suppression, overwrite-by-index and registered indexed read ports.
module elevator_req_queue
    import elevator_req_queue_pkg::*;
#(
    parameter int DATA_W = FLOOR_W,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int DEDUP  = 1,
    localparam int IDX_W = idx_w(DEPTH),
    // a zero-width request still needs one storage bit; it is simply always 0
    localparam int DW    = (DATA_W > 0) ? DATA_W : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DW-1:0]           push_data,
    input  logic                    pop,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DW-1:0]           wr_data,
    input  logic [NUM_RD*IDX_W-1:0] rd_idx,
    output logic [NUM_RD*DW-1:0]    rd_data,
    output logic [NUM_RD-1:0]       rd_valid,
    output logic [DW-1:0]           head,
    output logic                    head_valid,
    output logic [IDX_W:0]          count,
    output logic                    full,
    output logic                    empty,
    output logic                    push_drop
);

    localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [DW-1:0]    mem     [DEPTH];
    logic [DW-1:0]    mem_nxt [DEPTH];
    logic [IDX_W:0]   cnt;
    logic [IDX_W:0]   cnt_nxt;
    logic [DEPTH-1:0] dup_vec;
    logic             pop_eff;
    logic             has_space;
    logic             is_dup;
    logic             push_acc;
    logic             wr_ok;
    logic [IDX_W:0]   tail;
    logic [IDX_W-1:0] wr_tgt;
    logic             drop_q;

    assign pop_eff   = pop && (cnt != '0);
    assign has_space = (cnt < DEPTH_C) || pop_eff;

    // The entry being popped this cycle is not a duplicate of anything that stays.
    for (genvar i = 0; i < DEPTH; i++) begin : g_dup
        localparam logic [IDX_W:0] I_C = (IDX_W+1)'(i);
        assign dup_vec[i] = (mem[i] == push_data) && (I_C < cnt)
                            && (I_C >= {{IDX_W{1'b0}}, pop_eff});
    end

    assign is_dup   = (DEDUP != 0) && (|dup_vec);
    assign push_acc = push && has_space && !is_dup;
    assign tail     = pop_eff ? (cnt - CNT_ONE) : cnt;

    // Write position is relative to the pre-pop head; index 0 vanishes with the pop.
    assign wr_ok  = wr_en && ({1'b0, wr_idx} < cnt) && !(pop_eff && (wr_idx == '0));
    assign wr_tgt = pop_eff ? (wr_idx - IDX_ONE) : wr_idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_nxt[i] = mem[i];
        end
        if (pop_eff) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_nxt[i] = mem[i+1];
            end
            mem_nxt[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && (wr_tgt == IDX_W'(i))) begin
                mem_nxt[i] = wr_data;
            end
            if (push_acc && (tail == (IDX_W+1)'(i))) begin
                mem_nxt[i] = push_data;
            end
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (push_acc && !pop_eff) begin
            cnt_nxt = cnt + CNT_ONE;
        end else if (pop_eff && !push_acc) begin
            cnt_nxt = cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            cnt    <= '0;
            drop_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_nxt[i];
            end
            cnt    <= cnt_nxt;
            drop_q <= push && !push_acc;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [IDX_W-1:0] idx;
        logic [DW-1:0]    sel;
        logic             hit;
        logic [DW-1:0]    data_q;
        logic             valid_q;

        assign idx = rd_idx[k*IDX_W +: IDX_W];
        assign hit = ({1'b0, idx} < cnt);

        always_comb begin
            sel = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (idx == IDX_W'(i)) begin
                    sel = mem[i];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= hit ? sel : '0;
                valid_q <= hit;
            end
        end

        assign rd_data[k*DW +: DW] = data_q;
        assign rd_valid[k]         = valid_q;
    end

    assign head       = mem[0];
    assign head_valid = (cnt != '0);
    assign count      = cnt;
    assign full       = (cnt == DEPTH_C);
    assign empty      = (cnt == '0);
    assign push_drop  = drop_q;

endmodule

// File: tb/tb_elevator_req_queue.sv
// Bench for elevator_req_queue: directed scenarios plus randomized traffic against a queue model.
module tb_elevator_req_queue;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset, push, pop, wr_en;
    logic [3:0] push_data, wr_idx, wr_data;
    logic [7:0] rd_idx;

    logic [7:0] rd_data1, rd_data0;
    logic [1:0] rd_valid1, rd_valid0;
    logic [3:0] head1, head0;
    logic       head_valid1, head_valid0, full1, full0, empty1, empty0, drop1, drop0;
    logic [4:0] count1, count0;

    int n_cmp = 0;
    int n_bad = 0;

    int q1[$];
    int q0[$];
    int exp_rd0, exp_rd1;
    bit exp_rv0, exp_rv1, exp_drop1, exp_drop0;

    always #5 clk = ~clk;

    elevator_req_queue #(.DATA_W(4), .DEPTH(DEPTH), .NUM_RD(2), .DEDUP(1)) u_dut1 (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rd_idx(rd_idx),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .head(head1), .head_valid(head_valid1),
        .count(count1), .full(full1), .empty(empty1), .push_drop(drop1)
    );

    elevator_req_queue #(.DATA_W(4), .DEPTH(DEPTH), .NUM_RD(2), .DEDUP(0)) u_dut0 (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rd_idx(rd_idx),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .head(head0), .head_valid(head_valid0),
        .count(count0), .full(full0), .empty(empty0), .push_drop(drop0)
    );

    // Queue-level model of one cycle: reads see the old queue, then pop, overwrite, append.
    task automatic model_step(input int qi[$], input bit dd, output int qo[$], output bit drop,
                              output int rd0, output int rd1, output bit rv0, output bit rv1);
        int q[$];
        int n;
        int i0, i1, wi;
        bit pe, space, dup, acc;
        q  = qi;
        n  = q.size();
        i0 = int'(rd_idx[3:0]);
        i1 = int'(rd_idx[7:4]);
        wi = int'(wr_idx);
        rv0 = (i0 < n);
        rv1 = (i1 < n);
        rd0 = rv0 ? q[i0] : 0;
        rd1 = rv1 ? q[i1] : 0;
        pe    = pop && (n > 0);
        space = (n < DEPTH) || pe;
        dup   = 1'b0;
        if (dd) begin
            for (int j = (pe ? 1 : 0); j < n; j++) begin
                if (q[j] == int'(push_data)) dup = 1'b1;
            end
        end
        acc = push && space && !dup;
        if (pe) void'(q.pop_front());
        if (wr_en && (wi < n)) begin
            if (!pe) q[wi] = int'(wr_data);
            else if (wi >= 1) q[wi-1] = int'(wr_data);
        end
        if (acc) q.push_back(int'(push_data));
        drop = push && !acc;
        qo = q;
    endtask

    task automatic step(input bit rs, input bit p, input int pd, input bit po, input bit we,
                        input int wi, input int wd, input int r0, input int r1);
        int qn1[$];
        int qn0[$];
        int d0, d1;
        bit v0, v1;
        reset     = rs;
        push      = p;
        push_data = pd[3:0];
        pop       = po;
        wr_en     = we;
        wr_idx    = wi[3:0];
        wr_data   = wd[3:0];
        rd_idx    = {r1[3:0], r0[3:0]};
        if (rs) begin
            q1.delete();
            q0.delete();
            exp_rd0 = 0; exp_rd1 = 0; exp_rv0 = 0; exp_rv1 = 0;
            exp_drop1 = 0; exp_drop0 = 0;
        end else begin
            model_step(q1, 1'b1, qn1, exp_drop1, exp_rd0, exp_rd1, exp_rv0, exp_rv1);
            model_step(q0, 1'b0, qn0, exp_drop0, d0, d1, v0, v1);
            q1 = qn1;
            q0 = qn0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(1, 1, 3, 1, 1, 0, 4, 0, 1);
        n_cmp++; if (count1 !== 5'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count1); end
        n_cmp++; if (empty1 !== 1'b1 || full1 !== 1'b0 || head_valid1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags got empty=%b full=%b hv=%b exp 1/0/0", empty1, full1, head_valid1); end
        n_cmp++; if (rd_valid1 !== 2'b00 || rd_data1 !== 8'h00 || drop1 !== 1'b0 || head1 !== 4'd0) begin
            n_bad++; $display("FAIL reset_outputs got rv=%b rd=%h drop=%b head=%0d exp all 0", rd_valid1, rd_data1, drop1, head1); end
    endtask

    task automatic test_push_read();
        do_reset();
        step(0, 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (count1 !== 5'd3) begin n_bad++; $display("FAIL push_count got=%0d exp=3", count1); end
        n_cmp++; if (head1 !== 4'd2) begin n_bad++; $display("FAIL push_head got=%0d exp=2", head1); end
        step(0, 0, 0, 0, 0, 0, 0, 1, 2);
        n_cmp++; if (rd_data1 !== 8'h75 || rd_valid1 !== 2'b11) begin
            n_bad++; $display("FAIL read_ports got rd=%h rv=%b exp rd=75 rv=11", rd_data1, rd_valid1); end
    endtask

    task automatic test_dedup();
        do_reset();
        step(0, 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (count1 !== 5'd2 || drop1 !== 1'b1) begin
            n_bad++; $display("FAIL dedup_reject got count=%0d drop=%b exp 2/1", count1, drop1); end
        n_cmp++; if (count0 !== 5'd3 || drop0 !== 1'b0) begin
            n_bad++; $display("FAIL nodedup_accept got count=%0d drop=%b exp 3/0", count0, drop0); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (drop1 !== 1'b0) begin n_bad++; $display("FAIL drop_pulse got=%b exp=0", drop1); end
    endtask

    task automatic test_full();
        do_reset();
        step(0, 1, 9, 0, 0, 0, 0, 0, 0);
        for (int v = 0; v < 16; v++) begin
            if (v != 9) step(0, 1, v, 0, 0, 0, 0, 0, 0);
        end
        step(0, 1, 9, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (full1 !== 1'b1 || count1 !== 5'd16 || drop1 !== 1'b1) begin
            n_bad++; $display("FAIL full_reject got full=%b count=%0d drop=%b exp 1/16/1", full1, count1, drop1); end
        step(0, 1, 9, 1, 0, 0, 0, 0, 0);
        n_cmp++; if (count1 !== 5'd16 || head1 !== 4'd0 || drop1 !== 1'b0) begin
            n_bad++; $display("FAIL full_pushpop got count=%0d head=%0d drop=%b exp 16/0/0", count1, head1, drop1); end
        step(0, 0, 0, 0, 0, 0, 0, 15, 14);
        n_cmp++; if (rd_data1 !== 8'hF9 || rd_valid1 !== 2'b11) begin
            n_bad++; $display("FAIL full_tail got rd=%h rv=%b exp rd=f9 rv=11", rd_data1, rd_valid1); end
    endtask

    task automatic test_pop_push_dup();
        do_reset();
        step(0, 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2, 1, 0, 0, 0, 0, 0);
        n_cmp++; if (count1 !== 5'd3 || drop1 !== 1'b0 || head1 !== 4'd5) begin
            n_bad++; $display("FAIL poppush_dup got count=%0d drop=%b head=%0d exp 3/0/5", count1, drop1, head1); end
        step(0, 0, 0, 0, 0, 0, 0, 2, 3);
        n_cmp++; if (rd_data1 !== 8'h02 || rd_valid1 !== 2'b01) begin
            n_bad++; $display("FAIL poppush_tail got rd=%h rv=%b exp rd=02 rv=01", rd_data1, rd_valid1); end
    endtask

    task automatic test_overwrite();
        do_reset();
        step(0, 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 2, 3, 0, 0);
        n_cmp++; if (count1 !== 5'd2 || head1 !== 4'd5) begin
            n_bad++; $display("FAIL ovw_pop got count=%0d head=%0d exp 2/5", count1, head1); end
        step(0, 0, 0, 0, 0, 0, 0, 1, 2);
        n_cmp++; if (rd_data1 !== 8'h03 || rd_valid1 !== 2'b01) begin
            n_bad++; $display("FAIL ovw_read got rd=%h rv=%b exp rd=03 rv=01", rd_data1, rd_valid1); end
        step(0, 0, 0, 1, 1, 0, 9, 0, 0);
        n_cmp++; if (count1 !== 5'd1 || head1 !== 4'd3) begin
            n_bad++; $display("FAIL ovw_idx0_discard got count=%0d head=%0d exp 1/3", count1, head1); end
    endtask

    task automatic test_pop_empty();
        do_reset();
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        n_cmp++; if (count1 !== 5'd0 || empty1 !== 1'b1 || drop1 !== 1'b0) begin
            n_bad++; $display("FAIL pop_empty got count=%0d empty=%b drop=%b exp 0/1/0", count1, empty1, drop1); end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 4, 0, 0, 0, 0, 0, 0);
        step(0, 1, 6, 0, 0, 0, 0, 0, 0);
        step(1, 1, 8, 1, 0, 0, 0, 0, 1);
        n_cmp++; if (count1 !== 5'd0 || head1 !== 4'd0 || rd_valid1 !== 2'b00 || rd_data1 !== 8'h00) begin
            n_bad++; $display("FAIL reset_mid got count=%0d head=%0d rv=%b rd=%h exp all 0", count1, head1, rd_valid1, rd_data1); end
    endtask

    task automatic test_random();
        int eh;
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 7), $urandom_range(0, 15),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            eh = (q1.size() > 0) ? q1[0] : 0;
            n_cmp++; if (count1 !== 5'(q1.size()) || count0 !== 5'(q0.size())) begin
                n_bad++; $display("FAIL rnd_count c=%0d got=%0d/%0d exp=%0d/%0d", c, count1, count0, q1.size(), q0.size()); end
            n_cmp++; if (head1 !== 4'(eh) || head_valid1 !== (q1.size() > 0)) begin
                n_bad++; $display("FAIL rnd_head c=%0d got=%0d hv=%b exp=%0d", c, head1, head_valid1, eh); end
            n_cmp++; if (full1 !== (q1.size() == DEPTH) || empty1 !== (q1.size() == 0)) begin
                n_bad++; $display("FAIL rnd_flags c=%0d got full=%b empty=%b size=%0d", c, full1, empty1, q1.size()); end
            n_cmp++; if (drop1 !== exp_drop1 || drop0 !== exp_drop0) begin
                n_bad++; $display("FAIL rnd_drop c=%0d got=%b/%b exp=%b/%b", c, drop1, drop0, exp_drop1, exp_drop0); end
            n_cmp++; if (rd_data1 !== {4'(exp_rd1), 4'(exp_rd0)} || rd_valid1 !== {exp_rv1, exp_rv0}) begin
                n_bad++; $display("FAIL rnd_read c=%0d got rd=%h rv=%b exp rd=%h%h rv=%b%b",
                                  c, rd_data1, rd_valid1, 4'(exp_rd1), 4'(exp_rd0), exp_rv1, exp_rv0); end
        end
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; wr_en = 1'b0;
        push_data = '0; wr_idx = '0; wr_data = '0; rd_idx = '0;
        test_reset();
        test_push_read();
        test_dedup();
        test_full();
        test_pop_push_dup();
        test_overwrite();
        test_pop_empty();
        test_reset_mid();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
